// File: rtl/ascon_diffusion_folded.sv
// Folded Ascon linear diffusion layer: LANES_PER_CYCLE lanes per beat, in place.
// Optional bypass_i input under `ASCON_DIFF_BYPASS_EN.
package ascon_pack;
    typedef logic [4:0][63:0] type_state;
endpackage

module ascon_diffusion_folded
    import ascon_pack::*;
#(
    parameter int LANES_PER_CYCLE = 5
) (
    input  logic      clock_i,
    input  logic      resetb_i,
`ifdef ASCON_DIFF_BYPASS_EN
    input  logic      bypass_i,
`endif
    input  logic      valid_i,
    output logic      ready_o,
    input  type_state diffusion_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state diffusion_o
);

    localparam int NBEATS = (5 + LANES_PER_CYCLE - 1) / LANES_PER_CYCLE;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (LANES_PER_CYCLE < 1 || LANES_PER_CYCLE > 5) begin : g_bad_param
        $error("ascon_diffusion_folded: LANES_PER_CYCLE must be 1..5");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_fsm;
    state_t          w_fsm_nxt;
    type_state       r_state;
    type_state       w_state_nxt;
    type_state       w_diff;
    logic [BW-1:0]   r_beat;
    logic            w_last;
    logic            w_accept;
    logic            w_bypass;
    logic [4:0]      w_sel;
    int              w_base;

    // ROR(x, n) == {x[n-1:0], x[63:n]}
    assign w_diff[0] = r_state[0]
                     ^ {r_state[0][18:0], r_state[0][63:19]}
                     ^ {r_state[0][27:0], r_state[0][63:28]};
    assign w_diff[1] = r_state[1]
                     ^ {r_state[1][60:0], r_state[1][63:61]}
                     ^ {r_state[1][38:0], r_state[1][63:39]};
    assign w_diff[2] = r_state[2]
                     ^ {r_state[2][0],    r_state[2][63:1]}
                     ^ {r_state[2][5:0],  r_state[2][63:6]};
    assign w_diff[3] = r_state[3]
                     ^ {r_state[3][9:0],  r_state[3][63:10]}
                     ^ {r_state[3][16:0], r_state[3][63:17]};
    assign w_diff[4] = r_state[4]
                     ^ {r_state[4][6:0],  r_state[4][63:7]}
                     ^ {r_state[4][40:0], r_state[4][63:41]};

`ifdef ASCON_DIFF_BYPASS_EN
    logic r_bypass;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            r_bypass <= bypass_i;
        end
    end

    assign w_bypass = r_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_accept = (r_fsm == S_IDLE) && valid_i;
    assign w_last   = (r_beat == BW'(NBEATS - 1));
    assign w_base   = int'(r_beat) * LANES_PER_CYCLE;

    always_comb begin
        w_sel       = '0;
        w_state_nxt = r_state;
        for (int l = 0; l < 5; l++) begin
            w_sel[l] = (l >= w_base) && (l < w_base + LANES_PER_CYCLE);
            if (w_sel[l] && !w_bypass) begin
                w_state_nxt[l] = w_diff[l];
            end
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_fsm_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_fsm_nxt = S_DONE;
                end
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= '0;
            r_beat  <= '0;
        end else if (w_accept) begin
            r_state <= diffusion_i;
            r_beat  <= '0;
        end else if (r_fsm == S_BUSY) begin
            r_state <= w_state_nxt;
            if (!w_last) begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

    assign diffusion_o = r_state;

endmodule

// File: tb/tb_ascon_diffusion_folded.sv
// Directed bench for ascon_diffusion_folded at LANES_PER_CYCLE = 5, 1 and 2.
// Bypass steps are built only when ASCON_DIFF_BYPASS_EN is defined.
module tb_ascon_diffusion_folded;
    import ascon_pack::*;

    localparam logic [63:0] E0 = 64'h0000_2010_0000_0001;
    localparam logic [63:0] E1 = 64'h0000_0000_0200_0009;
    localparam logic [63:0] E2 = 64'h8400_0000_0000_0001;
    localparam logic [63:0] E3 = 64'h0040_8000_0000_0001;
    localparam logic [63:0] E4 = 64'h0200_0000_0080_0001;

    logic      clk;
    logic      rst_n;
    logic [2:0] vi, ri, ro, vo, byp;
    type_state din [3];
    type_state dout [3];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ascon_diffusion_folded #(.LANES_PER_CYCLE(5)) u5 (
        .clock_i(clk), .resetb_i(rst_n),
`ifdef ASCON_DIFF_BYPASS_EN
        .bypass_i(byp[0]),
`endif
        .valid_i(vi[0]), .ready_o(ro[0]), .diffusion_i(din[0]),
        .valid_o(vo[0]), .ready_i(ri[0]), .diffusion_o(dout[0])
    );

    ascon_diffusion_folded #(.LANES_PER_CYCLE(1)) u1 (
        .clock_i(clk), .resetb_i(rst_n),
`ifdef ASCON_DIFF_BYPASS_EN
        .bypass_i(byp[1]),
`endif
        .valid_i(vi[1]), .ready_o(ro[1]), .diffusion_i(din[1]),
        .valid_o(vo[1]), .ready_i(ri[1]), .diffusion_o(dout[1])
    );

    ascon_diffusion_folded #(.LANES_PER_CYCLE(2)) u2 (
        .clock_i(clk), .resetb_i(rst_n),
`ifdef ASCON_DIFF_BYPASS_EN
        .bypass_i(byp[2]),
`endif
        .valid_i(vi[2]), .ready_o(ro[2]), .diffusion_i(din[2]),
        .valid_o(vo[2]), .ready_i(ri[2]), .diffusion_o(dout[2])
    );

    task automatic chk(input string tag, input logic [319:0] obs,
                       input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present s, wait for valid_o; returns at a negedge inside DONE.
    task automatic run(input int k, input type_state s, output int lat);
        @(negedge clk);
        din[k] = s;
        vi[k]  = 1'b1;
        chk("ready_before_accept", 320'(ro[k]), 320'(1));
        @(negedge clk);
        vi[k] = 1'b0;
        lat = 0;
        while (!vo[k] && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    type_state s, e, imp, eimp, held;
    int        lat;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        vi    = '0;
        ri    = '1;
        byp   = '0;
        for (int k = 0; k < 3; k++) din[k] = '0;
        imp  = {64'h1, 64'h1, 64'h1, 64'h1, 64'h1};
        eimp = {E4, E3, E2, E1, E0};

        repeat (3) @(negedge clk);
        chk("rst_ready", 320'(ro), 320'(3'b111));
        chk("rst_valid", 320'(vo), 320'(3'b000));
        chk("rst_dout5", dout[0], '0);
        chk("rst_dout1", dout[1], '0);
        rst_n = 1'b1;

        s = '0; s[0] = 64'h1;
        e = '0; e[0] = E0;
        run(0, s, lat);
        chk("l5_lane0_lat", 320'(lat), 320'(1));
        chk("l5_lane0_val", dout[0], e);
        chk("l5_done_ready", 320'(ro[0]), 320'(0));

        run(0, imp, lat);
        chk("l5_imp_lat", 320'(lat), 320'(1));
        chk("l5_imp_val", dout[0], eimp);

        s = '0; s[0] = 64'h8000_0000_0000_0000;
        e = '0; e[0] = 64'h8000_1008_0000_0000;
        run(0, s, lat);
        chk("l5_msb_val", dout[0], e);

        s = '0; s[2] = 64'h1;
        e = '0; e[2] = E2;
        run(1, s, lat);
        chk("l1_lane2_lat", 320'(lat), 320'(5));
        chk("l1_lane2_val", dout[1], e);
        @(negedge clk);
        chk("l1_idle_after_done", 320'(ro[1]), 320'(1));

        run(1, imp, lat);
        chk("l1_imp_lat", 320'(lat), 320'(5));
        chk("l1_imp_val", dout[1], eimp);

        run(2, '1, lat);
        chk("l2_ones_lat", 320'(lat), 320'(3));
        chk("l2_ones_val", dout[2], '1);
        run(2, '0, lat);
        chk("l2_zero_lat", 320'(lat), 320'(3));
        chk("l2_zero_val", dout[2], '0);
        run(2, imp, lat);
        chk("l2_imp_lat", 320'(lat), 320'(3));
        chk("l2_imp_val", dout[2], eimp);

        // backpressure on the 5-lane instance
        ri[0] = 1'b0;
        s = '0; s[0] = 64'h1;
        held = '0; held[0] = E0;
        run(0, s, lat);
        din[0] = imp;
        vi[0]  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 320'(vo[0]), 320'(1));
            chk("bp_ready", 320'(ro[0]), 320'(0));
            chk("bp_stable", dout[0], held);
        end
        ri[0] = 1'b1;
        @(negedge clk);
        chk("bp_idle_ready", 320'(ro[0]), 320'(1));
        chk("bp_idle_valid", 320'(vo[0]), 320'(0));
        @(negedge clk);
        vi[0] = 1'b0;
        chk("bp_busy_valid", 320'(vo[0]), 320'(0));
        @(negedge clk);
        chk("bp_second_valid", 320'(vo[0]), 320'(1));
        chk("bp_second_val", dout[0], eimp);

        // reset mid-BUSY, lane-per-cycle instance at beat 2
        @(negedge clk);
        s = '0; s[0] = 64'h1;
        din[1] = s;
        vi[1]  = 1'b1;
        @(negedge clk);
        vi[1] = 1'b0;
        repeat (2) @(negedge clk);
        e = '0; e[0] = E0;
        chk("mid_partial", dout[1], e);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 320'(vo[1]), 320'(0));
        chk("mid_rst_ready", 320'(ro[1]), 320'(1));
        chk("mid_rst_dout", dout[1], '0);
        @(negedge clk);
        rst_n = 1'b1;
        s = '0; s[2] = 64'h1;
        e = '0; e[2] = E2;
        run(1, s, lat);
        chk("post_rst_lat", 320'(lat), 320'(5));
        chk("post_rst_val", dout[1], e);

`ifdef ASCON_DIFF_BYPASS_EN
        byp[0] = 1'b1;
        s = '0; s[0] = 64'h1;
        run(0, s, lat);
        byp[0] = 1'b0;
        chk("byp_lat", 320'(lat), 320'(1));
        chk("byp_val", dout[0], s);
        e = '0; e[0] = E0;
        run(0, s, lat);
        chk("nobyp_lat", 320'(lat), 320'(1));
        chk("nobyp_val", dout[0], e);
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
